// File: rtl/axis_out_unpack.sv
// Rebuilds ROWS-lane Y_BITS-wide output beats from wide AXIS beats of sign-padded words.
// Latency: input handshake at edge E0, m_valid rises after E1 at the earliest; one input beat per cycle.
// Backpressure: a completed beat waits for m_ready, then words stop moving and s_axis_tready drops.
module axis_out_unpack #(
  parameter int ROWS    = 8,
  parameter int Y_BITS  = 24,
  parameter int Y_PAD   = 32,
  parameter int S_WIDTH = 128
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic [S_WIDTH-1:0]     s_axis_tdata,
  input  logic [S_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [ROWS*Y_BITS-1:0] m_data,
  output logic [ROWS-1:0]        m_keep,
  output logic                   m_last,
  output logic                   err_keep,
  output logic                   err_pad
);

  localparam int W_IN = S_WIDTH / Y_PAD;
  localparam int FW   = $clog2(ROWS + 1);
  localparam int CW   = $clog2(W_IN + 1);

  // Input buffer: one unpadded beat plus read pointer and kept-word count
  logic                   rst_done;
  logic                   in_valid;
  logic                   in_last;
  logic [CW-1:0]          in_cnt;
  logic [CW-1:0]          in_ptr;
  logic [W_IN*Y_BITS-1:0] in_flat;

  // Assembly register; lanes at and above fill are always zero
  logic [ROWS*Y_BITS-1:0] asm_flat;
  logic [FW-1:0]          fill;

  int                     fill_i, ptr_i, avail_i, space_i, k_i, filled_i, cnt_i;
  logic                   take_all, complete, out_free, move, s_hs;
  logic [ROWS*Y_BITS-1:0] nxt_flat;
  logic [ROWS-1:0]        nxt_keep;
  logic [CW-1:0]          beat_cnt;
  logic                   beat_contig, beat_pad_bad;
  logic                   unused_keep;

  // Only one keep bit per padded word is meaningful
  assign unused_keep = ^s_axis_tkeep;

  // Word movement, beat completion and input ready
  always_comb begin
    fill_i   = int'(fill);
    ptr_i    = int'(in_ptr);
    avail_i  = in_valid ? (int'(in_cnt) - ptr_i) : 0;
    space_i  = ROWS - fill_i;
    k_i      = (avail_i < space_i) ? avail_i : space_i;
    filled_i = fill_i + k_i;
    take_all = in_valid && (k_i == avail_i);
    complete = in_valid && ((filled_i == ROWS) || (take_all && in_last));
    out_free = !m_valid || m_ready;
    move     = in_valid && (!complete || out_free);
    s_axis_tready = rst_done && (!in_valid || (move && take_all));
    s_hs     = s_axis_tvalid && s_axis_tready;
  end

  // Merge the words taken this cycle into the assembly lanes
  always_comb begin
    nxt_flat = asm_flat;
    nxt_keep = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int i = 0; i < W_IN; i++) begin
        if (r >= fill_i && r < filled_i && i == ptr_i + r - fill_i)
          nxt_flat[Y_BITS*r +: Y_BITS] = in_flat[Y_BITS*i +: Y_BITS];
      end
      nxt_keep[r] = (r < filled_i);
    end
  end

  // Incoming beat: kept-word count, keep contiguity and sign-pad checks
  always_comb begin
    cnt_i        = 0;
    beat_contig  = 1'b1;
    beat_pad_bad = 1'b0;
    for (int i = 0; i < W_IN; i++)
      if (s_axis_tkeep[i*Y_PAD/8]) cnt_i = cnt_i + 1;
    for (int i = 0; i < W_IN; i++) begin
      if (s_axis_tkeep[i*Y_PAD/8] != (i < cnt_i)) beat_contig = 1'b0;
      if (s_axis_tkeep[i*Y_PAD/8] &&
          (|s_axis_tdata[Y_PAD*i+Y_BITS-1 +: Y_PAD-Y_BITS+1]) &&
          !(&s_axis_tdata[Y_PAD*i+Y_BITS-1 +: Y_PAD-Y_BITS+1]))
        beat_pad_bad = 1'b1;
    end
    beat_cnt = CW'(cnt_i);
  end

  // Hold input ready low for the first cycle out of reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  // Input buffer load on handshake, pointer advance as words drain
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_valid <= 1'b0;
      in_last  <= 1'b0;
      in_cnt   <= '0;
      in_ptr   <= '0;
      in_flat  <= '0;
    end else if (s_hs) begin
      in_valid <= 1'b1;
      in_last  <= s_axis_tlast;
      in_cnt   <= beat_cnt;
      in_ptr   <= '0;
      for (int i = 0; i < W_IN; i++)
        in_flat[Y_BITS*i +: Y_BITS] <= s_axis_tdata[Y_PAD*i +: Y_BITS];
    end else if (move) begin
      if (take_all) in_valid <= 1'b0;
      else          in_ptr   <= in_ptr + CW'(k_i);
    end
  end

  // Assembly accumulates words and restarts empty after each completed beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      asm_flat <= '0;
      fill     <= '0;
    end else if (move) begin
      if (complete) begin
        asm_flat <= '0;
        fill     <= '0;
      end else begin
        asm_flat <= nxt_flat;
        fill     <= FW'(filled_i);
      end
    end
  end

  // Output register, held until the consumer accepts it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (move && complete) begin
      m_valid <= 1'b1;
      m_data  <= nxt_flat;
      m_keep  <= nxt_keep;
      m_last  <= take_all && in_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_keep <= 1'b0;
      err_pad  <= 1'b0;
    end else if (s_hs) begin
      err_keep <= err_keep | !beat_contig;
      err_pad  <= err_pad | beat_pad_bad;
    end
  end

endmodule

// File: tb/tb_axis_out_unpack.sv
// Directed bench for axis_out_unpack at ROWS=8, Y_BITS=24, Y_PAD=32, S_WIDTH=128.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
// Accepted output beats are collected into queues and compared against hand-built expectations.
module tb_axis_out_unpack;

  logic         aclk;
  logic         aresetn;
  logic         s_axis_tready;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic [127:0] s_axis_tdata;
  logic [15:0]  s_axis_tkeep;
  logic         m_ready;
  logic         m_valid;
  logic [191:0] m_data;
  logic [7:0]   m_keep;
  logic         m_last;
  logic         err_keep;
  logic         err_pad;

  int n_checks = 0;
  int n_fail   = 0;

  logic [191:0] q_data[$];
  logic [7:0]   q_keep[$];
  logic         q_last[$];

  axis_out_unpack #(.ROWS(8), .Y_BITS(24), .Y_PAD(32), .S_WIDTH(128)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .err_keep(err_keep), .err_pad(err_pad)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Record every beat that will be accepted at the next rising edge
  always @(negedge aclk) begin
    if (aresetn && m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_keep.push_back(m_keep);
      q_last.push_back(m_last);
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word value for index i; odd indices are negative so sign padding is exercised
  function automatic logic [23:0] val(input int i);
    logic [23:0] v;
    v = 24'(i);
    if (i % 2 == 1) v = v | 24'hF00000;
    return v;
  endfunction

  function automatic logic [31:0] sx(input logic [23:0] v);
    return {{8{v[23]}}, v};
  endfunction

  function automatic logic [127:0] beat4(input int first);
    return {sx(val(first+3)), sx(val(first+2)), sx(val(first+1)), sx(val(first))};
  endfunction

  function automatic logic [191:0] exp_data(input int first, input int n);
    logic [191:0] d;
    d = '0;
    for (int r = 0; r < n; r++) d[24*r +: 24] = val(first + r);
    return d;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
    int   guard;
    logic hs;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    guard = 0;
    hs    = 1'b0;
    while (!hs) begin
      @(negedge aclk);
      hs = s_axis_tready;
      tick();
      guard++;
      if (!hs && guard > 200) begin
        check("send_timeout", 0, 1);
        hs = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [191:0] d, input logic [7:0] k,
                             input logic l);
    int guard;
    guard = 0;
    while (q_data.size() == 0 && guard < 200) begin
      tick();
      guard++;
    end
    if (q_data.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_data"}, q_data.pop_front(), d);
      check({tag, "_keep"}, q_keep.pop_front(), k);
      check({tag, "_last"}, q_last.pop_front(), l);
    end
  endtask

  task automatic expect_idle(input string tag);
    repeat (6) tick();
    check({tag, "_no_extra_beats"}, q_data.size(), 0);
  endtask

  logic [191:0] held;
  logic [191:0] d4;
  int           guard;

  initial begin
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    m_ready       = 1'b1;

    // Reset state
    #23;
    check("rst_tready", s_axis_tready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_m_last", m_last, 0);
    check("rst_err_keep", err_keep, 0);
    check("rst_err_pad", err_pad, 0);
    tick();
    aresetn = 1'b1;
    repeat (2) tick();
    check("post_rst_tready", s_axis_tready, 1);

    // Two full beats form one output beat
    send(beat4(0), 16'hFFFF, 1'b0);
    send(beat4(4), 16'hFFFF, 1'b1);
    expect_beat("t1", exp_data(0, 8), 8'hFF, 1'b1);
    expect_idle("t1");

    // Partial final beat of two words
    send(beat4(10), 16'hFFFF, 1'b0);
    send(beat4(14), 16'hFFFF, 1'b0);
    send(beat4(18), 16'h00FF, 1'b1);
    expect_beat("t2a", exp_data(10, 8), 8'hFF, 1'b0);
    expect_beat("t2b", exp_data(18, 2), 8'h03, 1'b1);
    expect_idle("t2");

    // Output stalled for five cycles during a four-beat stream
    m_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++) send(beat4(20 + 4*b), 16'hFFFF, (b == 3));
      end
    join_none
    guard = 0;
    while (!m_valid && guard < 100) begin
      @(negedge aclk);
      guard++;
    end
    check("t3_valid_seen", m_valid, 1);
    held = m_data;
    check("t3_held_value", held, exp_data(20, 8));
    repeat (5) begin
      @(negedge aclk);
      check("t3_hold_data", m_data, held);
      check("t3_hold_valid", m_valid, 1);
    end
    check("t3_tready_low", s_axis_tready, 0);
    check("t3_nothing_taken", q_data.size(), 0);
    tick();
    m_ready = 1'b1;
    expect_beat("t3a", exp_data(20, 8), 8'hFF, 1'b0);
    expect_beat("t3b", exp_data(28, 8), 8'hFF, 1'b1);
    wait fork;
    expect_idle("t3");

    // Bad sign padding, then non-contiguous keep
    send({sx(val(3)), sx(val(2)), sx(val(1)), 32'h0080_0000}, 16'hFFFF, 1'b1);
    d4 = exp_data(0, 4);
    d4[23:0] = 24'h80_0000;
    expect_beat("t4a", d4, 8'h0F, 1'b1);
    check("t4_err_pad", err_pad, 1);
    check("t4_err_keep_clear", err_keep, 0);
    send(beat4(40), 16'h0F0F, 1'b1);
    expect_beat("t4b", exp_data(40, 2), 8'h03, 1'b1);
    check("t4_err_keep", err_keep, 1);
    check("t4_err_pad_sticky", err_pad, 1);

    // Zero-keep beats: dropped, flush with last, empty last
    send(beat4(90), 16'h0000, 1'b0);
    send(beat4(50), 16'h0FFF, 1'b0);
    send(128'd0, 16'h0000, 1'b1);
    expect_beat("t5a", exp_data(50, 3), 8'h07, 1'b1);
    send(128'd0, 16'h0000, 1'b1);
    expect_beat("t5b", 192'd0, 8'h00, 1'b1);
    expect_idle("t5");

    // Reset mid-packet discards buffered words
    send(beat4(60), 16'hFFFF, 1'b0);
    send(beat4(64), 16'h000F, 1'b0);
    repeat (3) tick();
    check("t6_pre_rst_no_beat", q_data.size(), 0);
    aresetn = 1'b0;
    #1;
    check("t6_rst_m_valid", m_valid, 0);
    check("t6_rst_m_data", m_data, 0);
    check("t6_rst_m_keep", m_keep, 0);
    check("t6_rst_m_last", m_last, 0);
    check("t6_rst_err_keep", err_keep, 0);
    check("t6_rst_err_pad", err_pad, 0);
    check("t6_rst_tready", s_axis_tready, 0);
    tick();
    aresetn = 1'b1;
    repeat (2) tick();
    send(beat4(70), 16'hFFFF, 1'b0);
    send(beat4(74), 16'hFFFF, 1'b1);
    expect_beat("t6", exp_data(70, 8), 8'hFF, 1'b1);
    expect_idle("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
